// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core FMA issue path: arbiter FSM states, FP op and rounding-mode enums.
// Optional build macro used by fma_share_arbiter: FMA_ARB_PERF_EN.
package bsg_vanilla_pkg;

  typedef enum logic [1:0] {
    e_fma_arb_run   = 2'd0,
    e_fma_arb_drain = 2'd1,
    e_fma_arb_done  = 2'd2
  } fma_arb_state_e;

  // e_fpu_nop is all-zero so an idle FMA input bus is quiet and reads 0
  typedef enum logic [3:0] {
    e_fpu_nop    = 4'd0,
    e_fpu_fadd   = 4'd1,
    e_fpu_fsub   = 4'd2,
    e_fpu_fmul   = 4'd3,
    e_fpu_fmadd  = 4'd4,
    e_fpu_fmsub  = 4'd5,
    e_fpu_fnmsub = 4'd6,
    e_fpu_fnmadd = 4'd7,
    e_fpu_imul   = 4'd8
  } fpu_float_op_e;

  typedef enum logic [2:0] {
    eRNE = 3'd0,
    eRTZ = 3'd1,
    eRDN = 3'd2,
    eRUP = 3'd3,
    eRMM = 3'd4,
    eDYN = 3'd7
  } frm_e;

  // Bits needed to hold the values 0..max_val inclusive
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fma_arb_starve_ctr.sv
// Saturating starvation counter for the FP requester: hold wins over clear, clear wins over increment.
module fma_arb_starve_ctr
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned limit_p = 4,
  parameter int unsigned width_p = cnt_width(limit_p)
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic hold_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic sat_o
);

  logic [width_p-1:0] cnt_q, cnt_n;

  always_comb begin
    cnt_n = cnt_q;
    if (!hold_i) begin
      if (clear_i) begin
        cnt_n = '0;
      end else if (inc_i && (cnt_q != width_p'(limit_p))) begin
        cnt_n = cnt_q + width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_n;
    end
  end

  assign sat_o = (cnt_q == width_p'(limit_p));

endmodule

// File: rtl/fma_share_arbiter.sv
// Shares FMA stage 1 between the integer multiplier and FP issue, counts in-flight FP ops and drains them for fcsr fences.
// Define FMA_ARB_PERF_EN to add conflict_cnt_o, a count of cycles where both requesters competed.
module fma_share_arbiter
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned recoded_width_p   = 33,
  parameter int unsigned max_outstanding_p = 2,
  parameter int unsigned starve_limit_p    = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       stall_fpu1_i,
  input  logic                       imul_v_i,
  output logic                       imul_ready_o,
  input  logic [data_width_p-1:0]    imul_rs1_i,
  input  logic [data_width_p-1:0]    imul_rs2_i,
  input  logic                       fp_v_i,
  output logic                       fp_ready_o,
  input  fpu_float_op_e              fp_op_i,
  input  logic [recoded_width_p-1:0] fp_rs1_i,
  input  logic [recoded_width_p-1:0] fp_rs2_i,
  input  logic [recoded_width_p-1:0] fp_rs3_i,
  input  frm_e                       fp_rm_i,
  output logic                       fma_imul_v_o,
  output logic                       fma_fp_v_o,
  output logic [data_width_p-1:0]    fma_imul_rs1_o,
  output logic [data_width_p-1:0]    fma_imul_rs2_o,
  output fpu_float_op_e              fma_fp_op_o,
  output logic [recoded_width_p-1:0] fma_fp_rs1_o,
  output logic [recoded_width_p-1:0] fma_fp_rs2_o,
  output logic [recoded_width_p-1:0] fma_fp_rs3_o,
  output frm_e                       fma_fp_rm_o,
  input  logic                       fp_retire_i,
  input  logic                       fence_req_i,
  output logic                       fence_done_o,
`ifdef FMA_ARB_PERF_EN
  output logic [31:0]                conflict_cnt_o,
`endif
  output logic                       busy_o
);

  localparam int unsigned out_w_lp = cnt_width(max_outstanding_p);

  fma_arb_state_e      state_q, state_n;
  logic [out_w_lp-1:0] out_cnt_q, out_cnt_n;
  logic                can_grant;
  logic                fp_allowed;
  logic                fp_prio;

  // Zero-latency grant; a fence arriving in RUN already blocks FP in that cycle
  always_comb begin
    can_grant    = reset_ni & ~stall_fpu1_i;
    fp_allowed   = (out_cnt_q != out_w_lp'(max_outstanding_p))
                 && (state_q == e_fma_arb_run) && !fence_req_i;
    fp_ready_o   = can_grant & fp_v_i & fp_allowed & (fp_prio | ~imul_v_i);
    imul_ready_o = can_grant & imul_v_i & ~fp_ready_o;
  end

  fma_arb_starve_ctr #(
    .limit_p (starve_limit_p)
  ) u_starve_ctr (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .hold_i   (stall_fpu1_i),
    .clear_i  (fp_ready_o | ~fp_v_i),
    .inc_i    (fp_v_i & ~fp_ready_o),
    .sat_o    (fp_prio)
  );

  // Ungranted lanes are held at zero so the FMA inputs do not toggle
  assign fma_imul_v_o   = imul_ready_o;
  assign fma_fp_v_o     = fp_ready_o;
  assign fma_imul_rs1_o = imul_ready_o ? imul_rs1_i : '0;
  assign fma_imul_rs2_o = imul_ready_o ? imul_rs2_i : '0;
  assign fma_fp_op_o    = fp_ready_o ? fp_op_i : e_fpu_nop;
  assign fma_fp_rs1_o   = fp_ready_o ? fp_rs1_i : '0;
  assign fma_fp_rs2_o   = fp_ready_o ? fp_rs2_i : '0;
  assign fma_fp_rs3_o   = fp_ready_o ? fp_rs3_i : '0;
  assign fma_fp_rm_o    = fp_ready_o ? fp_rm_i : eRNE;

  // In-flight FP count; a spurious retire at zero leaves the count at zero
  always_comb begin
    out_cnt_n = out_cnt_q;
    unique case ({fp_ready_o, fp_retire_i})
      2'b10:   out_cnt_n = out_cnt_q + out_w_lp'(1);
      2'b01:   if (out_cnt_q != '0) out_cnt_n = out_cnt_q - out_w_lp'(1);
      default: out_cnt_n = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_n;
    end
  end

  // Fence sequencing: DRAIN completes once the count is about to reach zero
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      e_fma_arb_run:   if (fence_req_i) state_n = e_fma_arb_drain;
      e_fma_arb_drain: if (out_cnt_n == '0) state_n = e_fma_arb_done;
      e_fma_arb_done:  state_n = e_fma_arb_run;
      default:         state_n = e_fma_arb_run;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= e_fma_arb_run;
    end else begin
      state_q <= state_n;
    end
  end

  assign fence_done_o = (state_q == e_fma_arb_done);
  assign busy_o       = (out_cnt_q != '0);

`ifdef FMA_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      conflict_cnt_o <= '0;
    end else if (imul_v_i && fp_v_i && !stall_fpu1_i) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

  a_no_retire_when_empty : assert property (
    @(posedge clk_i) disable iff (!reset_ni) !(fp_retire_i && (out_cnt_q == '0))
  ) else $error("fma_share_arbiter: fp_retire_i with no FP op outstanding");

endmodule

// File: tb/tb_fma_share_arbiter.sv
// Directed vector bench for fma_share_arbiter: cycle-by-cycle table plus a mid-drain reset sequence.
module tb_fma_share_arbiter;
  import bsg_vanilla_pkg::*;

  logic          clk_i;
  logic          reset_ni;
  logic          stall_fpu1_i;
  logic          imul_v_i;
  logic          imul_ready_o;
  logic [31:0]   imul_rs1_i, imul_rs2_i;
  logic          fp_v_i;
  logic          fp_ready_o;
  fpu_float_op_e fp_op_i;
  logic [32:0]   fp_rs1_i, fp_rs2_i, fp_rs3_i;
  frm_e          fp_rm_i;
  logic          fma_imul_v_o, fma_fp_v_o;
  logic [31:0]   fma_imul_rs1_o, fma_imul_rs2_o;
  fpu_float_op_e fma_fp_op_o;
  logic [32:0]   fma_fp_rs1_o, fma_fp_rs2_o, fma_fp_rs3_o;
  frm_e          fma_fp_rm_o;
  logic          fp_retire_i;
  logic          fence_req_i;
  logic          fence_done_o;
  logic          busy_o;
`ifdef FMA_ARB_PERF_EN
  logic [31:0]   conflict_cnt_o;
`endif

  fma_share_arbiter dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .stall_fpu1_i   (stall_fpu1_i),
    .imul_v_i       (imul_v_i),
    .imul_ready_o   (imul_ready_o),
    .imul_rs1_i     (imul_rs1_i),
    .imul_rs2_i     (imul_rs2_i),
    .fp_v_i         (fp_v_i),
    .fp_ready_o     (fp_ready_o),
    .fp_op_i        (fp_op_i),
    .fp_rs1_i       (fp_rs1_i),
    .fp_rs2_i       (fp_rs2_i),
    .fp_rs3_i       (fp_rs3_i),
    .fp_rm_i        (fp_rm_i),
    .fma_imul_v_o   (fma_imul_v_o),
    .fma_fp_v_o     (fma_fp_v_o),
    .fma_imul_rs1_o (fma_imul_rs1_o),
    .fma_imul_rs2_o (fma_imul_rs2_o),
    .fma_fp_op_o    (fma_fp_op_o),
    .fma_fp_rs1_o   (fma_fp_rs1_o),
    .fma_fp_rs2_o   (fma_fp_rs2_o),
    .fma_fp_rs3_o   (fma_fp_rs3_o),
    .fma_fp_rm_o    (fma_fp_rm_o),
    .fp_retire_i    (fp_retire_i),
    .fence_req_i    (fence_req_i),
    .fence_done_o   (fence_done_o),
`ifdef FMA_ARB_PERF_EN
    .conflict_cnt_o (conflict_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic iv, fv, st, rt, fn;     // imul_v, fp_v, stall, retire, fence_req
    logic eir, efr, ebz, edn;     // imul_ready, fp_ready, busy, fence_done
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vidx   = 0;

  function automatic vec_t mkv(input logic iv, fv, st, rt, fn, eir, efr, ebz, edn);
    vec_t v;
    v = {iv, fv, st, rt, fn, eir, efr, ebz, edn};
    return v;
  endfunction

  function automatic logic [175:0] observed();
    return {imul_ready_o, fp_ready_o, fma_imul_v_o, fma_fp_v_o, busy_o, fence_done_o,
            fma_imul_rs1_o, fma_imul_rs2_o, fma_fp_op_o,
            fma_fp_rs1_o, fma_fp_rs2_o, fma_fp_rs3_o, fma_fp_rm_o};
  endfunction

  // Expected bus derived from the vector flags and the operands currently driven
  function automatic logic [175:0] expected(input vec_t v);
    fpu_float_op_e op_e;
    frm_e          rm_e;
    op_e = v.efr ? fp_op_i : e_fpu_nop;
    rm_e = v.efr ? fp_rm_i : eRNE;
    return {v.eir, v.efr, v.eir, v.efr, v.ebz, v.edn,
            (v.eir ? imul_rs1_i : 32'd0), (v.eir ? imul_rs2_i : 32'd0), op_e,
            (v.efr ? fp_rs1_i : 33'd0), (v.efr ? fp_rs2_i : 33'd0),
            (v.efr ? fp_rs3_i : 33'd0), rm_e};
  endfunction

  task automatic compare(input string nm, input logic [175:0] exp_v);
    logic [175:0] obs;
    obs = observed();
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, obs, exp_v);
    end
  endtask

  // Called at a negedge: drive, check 2ns later, return at the next negedge
  task automatic apply_vec(input vec_t v, input string nm);
    imul_v_i     = v.iv;
    fp_v_i       = v.fv;
    stall_fpu1_i = v.st;
    fp_retire_i  = v.rt;
    fence_req_i  = v.fn;
    imul_rs1_i   = 32'hA500_0000 | 32'(vidx);
    imul_rs2_i   = 32'h5A00_0000 ^ 32'(vidx * 3);
    fp_rs1_i     = {1'b1, 32'hF000_0000 | 32'(vidx)};
    fp_rs2_i     = {1'b0, 32'h0F00_0000 | 32'(vidx)};
    fp_rs3_i     = {1'b1, 32'h00F0_0000 | 32'(vidx)};
    fp_op_i      = vidx[0] ? e_fpu_fmul : e_fpu_fmadd;
    fp_rm_i      = vidx[1] ? eRDN : eRUP;
    vidx++;
    #2;
    compare(nm, expected(v));
    @(negedge clk_i);
  endtask

  initial begin
    // Reset with every request active: all outputs must stay at 0
    reset_ni     = 1'b0;
    imul_v_i     = 1'b1;
    fp_v_i       = 1'b1;
    stall_fpu1_i = 1'b0;
    fp_retire_i  = 1'b0;
    fence_req_i  = 1'b1;
    imul_rs1_i   = 32'hDEAD_BEEF;
    imul_rs2_i   = 32'h1234_5678;
    fp_op_i      = e_fpu_fmadd;
    fp_rs1_i     = 33'h1_FFFF_FFFF;
    fp_rs2_i     = 33'h0_AAAA_AAAA;
    fp_rs3_i     = 33'h1_5555_5555;
    fp_rm_i      = eRMM;
    #3;
    compare("reset_outputs", 176'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    //           iv fv st rt fn  ir fr bz dn
    // Starvation: imul wins 4 cycles, FP on the 5th, imul again after
    repeat (4) vecs.push_back(mkv(1, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Outstanding limit: 2 grants, 3rd blocked until a retire frees a slot
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1, 1, 0));
    // Fence at N with 2 in flight, retires at N+1 and N+3, done at N+4
    vecs.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mkv(1, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mkv(1, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Stall holds the starve count: 2 before, 5 stalled, FP wins 3 cycles later
    repeat (2) vecs.push_back(mkv(1, 1, 0, 0, 0, 1, 0, 0, 0));
    repeat (5) vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) vecs.push_back(mkv(1, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0));
    // Grant and retire together at count 1 leaves the count at 1
    vecs.push_back(mkv(0, 1, 0, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Fence in RUN blocks FP that same cycle, then reset arrives mid-DRAIN
    apply_vec(mkv(0, 1, 0, 0, 0, 0, 1, 0, 0), "seq_fp_grant");
    apply_vec(mkv(0, 1, 0, 0, 1, 0, 0, 1, 0), "seq_fence_blocks_fp");
    imul_v_i    = 1'b1;
    fp_v_i      = 1'b1;
    fence_req_i = 1'b1;
    #2;
    compare("seq_drain_imul_only", expected(mkv(1, 1, 0, 0, 1, 1, 0, 1, 0)));
    #1 reset_ni = 1'b0;
    #1;
    compare("seq_async_reset_zero", 176'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    apply_vec(mkv(0, 1, 0, 0, 0, 0, 1, 0, 0), "seq_back_in_run");
    apply_vec(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0), "seq_count_one");
    apply_vec(mkv(0, 0, 0, 1, 0, 0, 0, 1, 0), "seq_retire");
    apply_vec(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0), "seq_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
